alu_pd_core: RTL and testbench
==============================

Name: alu_pd_core

Overview:
- 16-bit ALU inside a switchable power domain, with integrated output isolation clamps.
- Takes two operands and a 4-bit opcode, qualified by a start pulse; drives a registered result and a busy flag.
- The top level registers the result into the always-on block, so every output must be clean: 0 when the domain is off or isolated.
- One clock; reset is synchronous and active-low.

Parameters:
- WIDTH, 16, operand/result width (only 16 is verified).
- MUL_CYCLES, 16, iteration count of the sequential multiplier; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- alu_pwr_en  input  1  domain power enable; 0 means the domain is off.
- iso_en  input  1  output isolation request; 1 means clamp outputs.
- A  input  16  operand A.
- B  input  16  operand B; B[3:0] is the shift/rotate amount.
- opcode  input  4  operation select.
- start  input  1  one-cycle request; sampled at clk edge.
- result  output  16  registered result, after isolation clamp.
- busy  output  1  multi-cycle operation in progress, after isolation clamp.

Behaviour:
- Reset: on a clk edge with rst_n=0, the result register, busy, the multiplier state and the counter all clear to 0.
- Opcodes:
  - 0 ADD A+B (mod 2^16); 1 SUB A-B (mod 2^16).
  - 2 AND; 3 OR; 4 XOR; 5 NOT A.
  - 6 SHL A by B[3:0]; 7 SHR logical; 8 SRA arithmetic.
  - 9 ROL; A ROR.
  - B SLT signed (result 1 or 0); C SLTU unsigned (result 1 or 0).
  - D MUL, low 16 bits of the unsigned product; E MULH, high 16 bits of the unsigned product.
  - F PASS B.
- Single-cycle ops (everything except D and E):
  - A start sampled high with busy=0 and alu_pwr_en=1 loads the result register at that edge, so the result is visible one cycle after start.
  - busy stays 0.
- MUL/MULH:
  - The accepting edge latches A, B and opcode, sets busy=1 and loads the counter with MUL_CYCLES.
  - Shift-add proceeds one bit per cycle.
  - On the 16th following edge: result is updated, busy falls to 0, and the counter reaches 0.
  - Total latency is 17 edges from the start edge to the new result.
  - The result register holds its old value until then.
- start while busy=1 is ignored (no queueing). Operand changes during busy have no effect.
- Power off (alu_pwr_en=0):
  - At each edge, result register, busy, counter and multiplier state clear to 0, regardless of start.
  - An in-flight multiply is aborted.
  - On re-power, the block resumes from the cleared state.
- Isolation:
  - result = iso_en ? 0 : result register; busy = iso_en ? 0 : internal busy. Both combinational.
  - The internal state keeps running while isolated.
  - start is accepted while isolated if power is on.
  - Deasserting iso_en exposes the internal value immediately.
- Simultaneous events:
  - Reset has priority over power-off.
  - Power-off has priority over start.
  - Isolation affects outputs only.

Optional Feature:
- Macro ALU_RETENTION_EN.
- Defined: the result register is a retention register. Power-off aborts the multiply and clears busy, but the result register holds its value. After re-power, result shows the pre-power-down value until the next completed operation. Reset still clears it.
- Undefined: the result register clears during power-off, as specified above.

Decomposition:
- Package alu_pd_pkg holds:
  - WIDTH;
  - an opcode enum (OP_ADD … OP_PASSB, values 0x0–0xF);
  - a helper function is_multicycle(opcode).
- Sub-module alu_seq_mult: the iterative 16x16 shift-add multiplier.
  - Ports: clk, rst_n, clr (from !alu_pwr_en), start, a, b, done, product[31:0].
  - The top-level block selects the low or high half of product.

Test Plan:
- Reset then power on, iso_en=0 → result=0x0000, busy=0. Then ADD A=0x1234 B=0x0001 with start → result=0x1235 one cycle later.
- SUB A=0x0000 B=0x0001 → 0xFFFF. SRA A=0x8000 B=0x0004 → 0xF800. SLT A=0xFFFF B=0x0001 → 0x0001. SLTU with the same operands → 0x0000.
- MUL A=0x0100 B=0x0100 (opcode D) → busy=1 for 16 cycles, then result=0x0000. MULH (opcode E) with the same operands → result=0x0001. A second start during busy is ignored.
- After result=0x1235, raise iso_en → result=0x0000 and busy=0 the same cycle. Drop iso_en → 0x1235 returns.
- Start MULH and drop alu_pwr_en mid-operation → busy=0 and result=0x0000 at the next edge. Re-power → result stays 0 until a new start (0x1235 retained instead if ALU_RETENTION_EN is defined).
- Assert rst_n=0 during a busy multiply → result=0 and busy=0 at the next edge.

Source files
------------

// File: rtl/alu_pd_pkg.sv
// Shared definitions for the power-gated ALU: widths, opcode encoding and op classification.
// The optional retention behaviour is controlled by the ALU_RETENTION_EN macro in alu_pd_core.
package alu_pd_pkg;

   localparam int WIDTH      = 16;
   localparam int MUL_CYCLES = WIDTH;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NOT   = 4'h5,
      OP_SHL   = 4'h6,
      OP_SHR   = 4'h7,
      OP_SRA   = 4'h8,
      OP_ROL   = 4'h9,
      OP_ROR   = 4'hA,
      OP_SLT   = 4'hB,
      OP_SLTU  = 4'hC,
      OP_MUL   = 4'hD,
      OP_MULH  = 4'hE,
      OP_PASSB = 4'hF
   } opcode_e;

   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULH);
   endfunction

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done pulses combinationally on the cycle whose edge produces the final product.
module alu_seq_mult
   import alu_pd_pkg::*;
#(
   parameter int W      = WIDTH,
   parameter int CYCLES = MUL_CYCLES
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [2*W-1:0] mcand_q, mcand_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      done     = 1'b0;
      if (clr) begin
         mcand_d  = '0;
         acc_d    = '0;
         mplier_d = '0;
         cnt_d    = '0;
      end else if (cnt_q != '0) begin
         // A running multiply ignores start; the top only offers one when idle.
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
         done     = (cnt_q == CW'(1));
      end else if (start) begin
         mcand_d  = {{W{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = CW'(CYCLES);
      end
   end

   assign product = acc_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_pd_core.sv
// 16-bit ALU in a switchable power domain with output isolation clamps.
// Define ALU_RETENTION_EN to make the result register hold its value through power-off.
module alu_pd_core
   import alu_pd_pkg::*;
#(
   parameter int MUL_CYCLES_P = MUL_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_pwr_en,
   input  logic             iso_en,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opcode,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   logic [WIDTH-1:0]   result_q, result_d;
   logic               busy_q, busy_d;
   logic               mulh_q, mulh_d;
   logic [WIDTH-1:0]   alu_out;
   logic [2*WIDTH-1:0] rot_l, rot_r;
   logic [3:0]         amt;
   logic               accept;
   logic               mult_done;
   logic [2*WIDTH-1:0] product;

   assign amt    = B[3:0];
   assign accept = start && !busy_q && alu_pwr_en;

   // Rotates come from shifting a doubled copy of A.
   always_comb begin
      rot_l   = {A, A} << amt;
      rot_r   = {A, A} >> amt;
      alu_out = '0;
      case (opcode_e'(opcode))
         OP_ADD:   alu_out = A + B;
         OP_SUB:   alu_out = A - B;
         OP_AND:   alu_out = A & B;
         OP_OR:    alu_out = A | B;
         OP_XOR:   alu_out = A ^ B;
         OP_NOT:   alu_out = ~A;
         OP_SHL:   alu_out = A << amt;
         OP_SHR:   alu_out = A >> amt;
         OP_SRA:   alu_out = $signed(A) >>> amt;
         OP_ROL:   alu_out = rot_l[2*WIDTH-1:WIDTH];
         OP_ROR:   alu_out = rot_r[WIDTH-1:0];
         OP_SLT:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU:  alu_out = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_PASSB: alu_out = B;
         default:  alu_out = '0;
      endcase
   end

   alu_seq_mult #(
      .W      (WIDTH),
      .CYCLES (MUL_CYCLES_P)
   ) u_mult (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!alu_pwr_en),
      .start   (accept && is_multicycle(opcode)),
      .a       (A),
      .b       (B),
      .done    (mult_done),
      .product (product)
   );

   always_comb begin
      result_d = result_q;
      busy_d   = busy_q;
      mulh_d   = mulh_q;
      if (!alu_pwr_en) begin
`ifdef ALU_RETENTION_EN
         result_d = result_q;
`else
         result_d = '0;
`endif
         busy_d   = 1'b0;
         mulh_d   = 1'b0;
      end else if (busy_q) begin
         if (mult_done) begin
            result_d = mulh_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
            busy_d   = 1'b0;
         end
      end else if (start) begin
         if (is_multicycle(opcode)) begin
            busy_d = 1'b1;
            mulh_d = (opcode == OP_MULH);
         end else begin
            result_d = alu_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q <= '0;
         busy_q   <= 1'b0;
         mulh_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         busy_q   <= busy_d;
         mulh_q   <= mulh_d;
      end
   end

   assign result = iso_en ? '0 : result_q;
   assign busy   = iso_en ? 1'b0 : busy_q;

endmodule

// File: tb/tb_alu_pd_core.sv
// Self-checking bench for alu_pd_core: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_alu_pd_core;
   import alu_pd_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_pwr_en;
   logic        iso_en;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic [3:0]  opcode;
   logic        start;
   logic [15:0] result;
   logic        busy;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_res  = 16'h0000;

   alu_pd_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_pwr_en (alu_pwr_en),
      .iso_en     (iso_en),
      .A          (a_in),
      .B          (b_in),
      .opcode     (opcode),
      .start      (start),
      .result     (result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int unsigned ua = a;
      int unsigned ub = b;
      int unsigned n  = b[3:0];
      int          sa = $signed(a);
      int          sb = $signed(b);
      logic [31:0] r;
      case (op)
         4'h0: r = ua + ub;
         4'h1: r = ua - ub;
         4'h2: r = ua & ub;
         4'h3: r = ua | ub;
         4'h4: r = ua ^ ub;
         4'h5: r = ~ua;
         4'h6: r = ua << n;
         4'h7: r = ua >> n;
         4'h8: r = sa >>> n;
         4'h9: r = (ua << n) | (ua >> (16 - n));
         4'hA: r = (ua >> n) | (ua << (16 - n));
         4'hB: r = (sa < sb) ? 32'd1 : 32'd0;
         4'hC: r = (ua < ub) ? 32'd1 : 32'd0;
         4'hD: r = ua * ub;
         4'hE: r = (ua * ub) >> 16;
         default: r = ub;
      endcase
      return r[15:0];
   endfunction

   // Issue one op; multiplies get stray starts and operand churn while busy.
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic iso);
      logic [15:0] exp_new;
      logic [15:0] prev;
      logic [15:0] vis_busy;
      exp_new = model(op, a, b);
      prev    = exp_res;
      iso_en  = iso;
      opcode  = op;
      a_in    = a;
      b_in    = b;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      if (is_multicycle(op)) begin
         vis_busy = iso ? 16'h0000 : 16'h0001;
         check("mul_busy", {15'd0, busy}, vis_busy);
         check("mul_hold", result, iso ? 16'h0000 : prev);
         for (int i = 1; i < 16; i++) begin
            start  = 1'($urandom_range(0, 1));
            opcode = 4'($urandom_range(0, 15));
            a_in   = 16'($urandom);
            b_in   = 16'($urandom);
            tick();
            check("mul_busy_run", {15'd0, busy}, vis_busy);
            check("mul_hold_run", result, iso ? 16'h0000 : prev);
         end
         start = 1'b0;
         tick();
      end
      exp_res = exp_new;
      $display("op=%h A=%04h B=%04h iso=%0d -> result=%04h exp=%04h", op, a, b, iso, result, iso ? 16'h0000 : exp_new);
      check("op_result", result, iso ? 16'h0000 : exp_new);
      check("op_busy_end", {15'd0, busy}, 16'h0000);
      if (iso) begin
         iso_en = 1'b0;
         #1;
         check("deiso_result", result, exp_new);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] exp_pd;
      rst_n      = 1'b0;
      alu_pwr_en = 1'b1;
      iso_en     = 1'b0;
      a_in       = 16'h0000;
      b_in       = 16'h0000;
      opcode     = 4'h0;
      start      = 1'b0;
      #2;
      tick();
      tick();
      check("reset_result", result, 16'h0000);
      check("reset_busy", {15'd0, busy}, 16'h0000);
      rst_n = 1'b1;

      run_op(OP_ADD, 16'h1234, 16'h0001, 1'b0);

      iso_en = 1'b1;
      #1;
      check("iso_result", result, 16'h0000);
      check("iso_busy", {15'd0, busy}, 16'h0000);
      iso_en = 1'b0;
      #1;
      check("iso_release", result, 16'h1235);

      run_op(OP_SUB,  16'h0000, 16'h0001, 1'b0);
      run_op(OP_SRA,  16'h8000, 16'h0004, 1'b0);
      run_op(OP_SLT,  16'hFFFF, 16'h0001, 1'b0);
      run_op(OP_SLTU, 16'hFFFF, 16'h0001, 1'b0);
      run_op(OP_MUL,  16'h0100, 16'h0100, 1'b0);
      run_op(OP_MULH, 16'h0100, 16'h0100, 1'b0);
      run_op(OP_ROL,  16'h8001, 16'h0000, 1'b0);
      run_op(OP_MULH, 16'hFFFF, 16'hFFFF, 1'b1);

      // Power-off mid-multiply, then re-power without a new start.
      run_op(OP_ADD, 16'h1234, 16'h0001, 1'b0);
      opcode = OP_MULH;
      a_in   = 16'h0100;
      b_in   = 16'h0100;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      tick();
      alu_pwr_en = 1'b0;
      start      = 1'b1;
      tick();
      start      = 1'b0;
`ifdef ALU_RETENTION_EN
      exp_pd = 16'h1235;
`else
      exp_pd = 16'h0000;
`endif
      check("pwroff_busy", {15'd0, busy}, 16'h0000);
      check("pwroff_result", result, exp_pd);
      alu_pwr_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      check("repower_result", result, exp_pd);
      check("repower_busy", {15'd0, busy}, 16'h0000);
      exp_res = exp_pd;

      // Reset in the middle of a multiply.
      run_op(OP_XOR, 16'hA5A5, 16'h0F0F, 1'b0);
      opcode = OP_MUL;
      a_in   = 16'h1234;
      b_in   = 16'h5678;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      rst_n  = 1'b0;
      tick();
      check("rst_busy_result", result, 16'h0000);
      check("rst_busy_busy", {15'd0, busy}, 16'h0000);
      rst_n   = 1'b1;
      exp_res = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      check("rst_no_late_done", result, 16'h0000);

      for (int i = 0; i < 120; i++) begin
         run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
